// File: rtl/execute_stage_md_if.sv
// Decode-to-execute and execute-to-memory signal bundle for execute_stage_md.
// master drives the E-stage inputs and observes the M register; slave is the execute stage.
interface execute_stage_md_if #(
    parameter int XLEN = 32,
    parameter int REGW = 5
);
    logic            FlushE;
    logic            RegWriteE;
    logic            MemWriteE;
    logic            ResultSrcE;
    logic            JumpE;
    logic            ALUSrcE;
    logic [2:0]      ALUControlE;
    logic            MulDivE;
    logic [1:0]      MDOpE;
    logic [XLEN-1:0] RD1_E;
    logic [XLEN-1:0] RD2_E;
    logic [XLEN-1:0] Imm_Ext_E;
    logic [XLEN-1:0] PCPlus4E;
    logic [XLEN-1:0] ResultW;
    logic [REGW-1:0] RD_E;
    logic [1:0]      ForwardA_E;
    logic [1:0]      ForwardB_E;

    logic            StallE;
    logic            PCSrcE;
    logic            RegWriteM;
    logic            MemWriteM;
    logic            ResultSrcM;
    logic [REGW-1:0] RD_M;
    logic [XLEN-1:0] PCPlus4M;
    logic [XLEN-1:0] WriteDataM;
    logic [XLEN-1:0] ALU_ResultM;

    modport master (
        output FlushE, RegWriteE, MemWriteE, ResultSrcE, JumpE, ALUSrcE,
               ALUControlE, MulDivE, MDOpE, RD1_E, RD2_E, Imm_Ext_E,
               PCPlus4E, ResultW, RD_E, ForwardA_E, ForwardB_E,
        input  StallE, PCSrcE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
               PCPlus4M, WriteDataM, ALU_ResultM
    );

    modport slave (
        input  FlushE, RegWriteE, MemWriteE, ResultSrcE, JumpE, ALUSrcE,
               ALUControlE, MulDivE, MDOpE, RD1_E, RD2_E, Imm_Ext_E,
               PCPlus4E, ResultW, RD_E, ForwardA_E, ForwardB_E,
        output StallE, PCSrcE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
               PCPlus4M, WriteDataM, ALU_ResultM
    );
endinterface

// File: rtl/execute_stage_md.sv
// Execute stage: single-cycle ALU, 3:1 forwarding, E/M register and an iterative mul/div unit.
// Define EXEC_FAST_MUL_EN for a single-cycle MUL/MULHU; DIVU/REMU always stay iterative.
module execute_stage_md #(
    parameter int XLEN = 32,
    parameter int REGW = 5,
    parameter int CNTW = $clog2(XLEN)
) (
    input logic               clk,
    input logic               rst,
    execute_stage_md_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} md_state_t;

    md_state_t       r_state;
    logic [CNTW-1:0] r_cnt;
    logic [1:0]      r_mdop;
    logic [XLEN-1:0] r_opnd;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;

    logic            r_regwrite;
    logic            r_memwrite;
    logic            r_resultsrc;
    logic [REGW-1:0] r_rd;
    logic [XLEN-1:0] r_pcplus4;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_alu_result;

    logic [XLEN-1:0] w_src_a;
    logic [XLEN-1:0] w_src_b_int;
    logic [XLEN-1:0] w_src_b;
    logic [CNTW-1:0] w_shamt;
    logic [XLEN-1:0] w_alu;
    logic [XLEN-1:0] w_e_result;
    logic [XLEN-1:0] w_md_res;
    logic [XLEN-1:0] w_m_res;
    logic            w_md_iter;
    logic            w_m_capture;
    logic [XLEN:0]   w_mul_sum;
    logic [XLEN:0]   w_div_shift;
    logic [XLEN:0]   w_div_diff;

    always_comb begin
        unique case (bus.ForwardA_E)
            2'b01:   w_src_a = bus.ResultW;
            2'b10:   w_src_a = r_alu_result;
            default: w_src_a = bus.RD1_E;
        endcase
        unique case (bus.ForwardB_E)
            2'b01:   w_src_b_int = bus.ResultW;
            2'b10:   w_src_b_int = r_alu_result;
            default: w_src_b_int = bus.RD2_E;
        endcase
    end

    assign w_src_b = bus.ALUSrcE ? bus.Imm_Ext_E : w_src_b_int;
    assign w_shamt = w_src_b[CNTW-1:0];

    always_comb begin
        w_alu = '0;
        unique case (bus.ALUControlE)
            3'b000:  w_alu = w_src_a + w_src_b;
            3'b001:  w_alu = w_src_a - w_src_b;
            3'b010:  w_alu = w_src_a & w_src_b;
            3'b011:  w_alu = w_src_a | w_src_b;
            3'b100:  w_alu = w_src_a ^ w_src_b;
            3'b101:  w_alu = {{(XLEN-1){1'b0}}, ($signed(w_src_a) < $signed(w_src_b))};
            3'b110:  w_alu = w_src_a << w_shamt;
            default: w_alu = w_src_a >> w_shamt;
        endcase
    end

`ifdef EXEC_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fast_prod;

    assign w_fast_prod = {{XLEN{1'b0}}, w_src_a} * {{XLEN{1'b0}}, w_src_b};
    assign w_md_iter   = bus.MulDivE && bus.MDOpE[1];
    assign w_e_result  = !bus.MulDivE ? w_alu :
                         (bus.MDOpE[0] ? w_fast_prod[2*XLEN-1:XLEN] : w_fast_prod[XLEN-1:0]);
`else
    assign w_md_iter   = bus.MulDivE;
    assign w_e_result  = w_alu;
`endif

    // Shared {r_hi,r_lo} datapath: mul keeps {partial product, multiplier},
    // div keeps {remainder, quotient/dividend}; r_opnd is multiplicand or divisor.
    assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
    assign w_div_shift = {r_hi, r_lo[XLEN-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opnd};

    assign w_md_res    = r_mdop[0] ? r_hi : r_lo;
    assign w_m_capture = ((r_state == S_IDLE) && !w_md_iter) || (r_state == S_DONE);
    assign w_m_res     = (r_state == S_DONE) ? w_md_res : w_e_result;

    assign bus.StallE  = rst && !bus.FlushE &&
                         (((r_state == S_IDLE) && w_md_iter) || (r_state == S_BUSY));
    assign bus.PCSrcE  = bus.JumpE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_mdop       <= '0;
            r_opnd       <= '0;
            r_hi         <= '0;
            r_lo         <= '0;
            r_regwrite   <= 1'b0;
            r_memwrite   <= 1'b0;
            r_resultsrc  <= 1'b0;
            r_rd         <= '0;
            r_pcplus4    <= '0;
            r_wdata      <= '0;
            r_alu_result <= '0;
        end else begin
            if (bus.FlushE) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (w_md_iter) begin
                            r_mdop  <= bus.MDOpE;
                            r_opnd  <= bus.MDOpE[1] ? w_src_b : w_src_a;
                            r_lo    <= bus.MDOpE[1] ? w_src_a : w_src_b;
                            r_hi    <= '0;
                            r_cnt   <= CNTW'(XLEN - 1);
                            r_state <= S_BUSY;
                        end
                    end
                    S_BUSY: begin
                        if (r_mdop[1]) begin
                            r_hi <= w_div_diff[XLEN] ? w_div_shift[XLEN-1:0] : w_div_diff[XLEN-1:0];
                            r_lo <= {r_lo[XLEN-2:0], ~w_div_diff[XLEN]};
                        end else begin
                            r_hi <= w_mul_sum[XLEN:1];
                            r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
                        end
                        if (r_cnt == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt - CNTW'(1);
                        end
                    end
                    S_DONE: r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end

            // Bubbles clear only controls and destination; data fields hold.
            if (bus.FlushE || !w_m_capture) begin
                r_regwrite  <= 1'b0;
                r_memwrite  <= 1'b0;
                r_resultsrc <= 1'b0;
                r_rd        <= '0;
            end else begin
                r_regwrite   <= bus.RegWriteE;
                r_memwrite   <= bus.MemWriteE;
                r_resultsrc  <= bus.ResultSrcE;
                r_rd         <= bus.RD_E;
                r_pcplus4    <= bus.PCPlus4E;
                r_wdata      <= w_src_b_int;
                r_alu_result <= w_m_res;
            end
        end
    end

    assign bus.RegWriteM   = r_regwrite;
    assign bus.MemWriteM   = r_memwrite;
    assign bus.ResultSrcM  = r_resultsrc;
    assign bus.RD_M        = r_rd;
    assign bus.PCPlus4M    = r_pcplus4;
    assign bus.WriteDataM  = r_wdata;
    assign bus.ALU_ResultM = r_alu_result;
endmodule
